// File: rtl/telemetry_frame_fmt_pkg.sv
// Shared constants, state encoding and small helpers for the telemetry frame formatter.
package telemetry_pkg;

  localparam int FRAME_LEN = 15;

  localparam logic [7:0] ASC_H     = 8'h48;
  localparam logic [7:0] ASC_R     = 8'h52;
  localparam logic [7:0] ASC_S     = 8'h53;
  localparam logic [7:0] ASC_P     = 8'h50;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_COMMA = 8'h2C;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_ZERO  = 8'h30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SEND    = 2'd2
  } state_e;

  // Shift-add-3 correction applied to one BCD digit before each shift.
  function automatic logic [3:0] dd_adjust(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return ASC_ZERO | {4'd0, d};
  endfunction

  // Byte idx of "HR:ddd,SP:ddd\r\n"; bcd vectors are {hundreds, tens, units}.
  function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                            input logic [11:0] hr_bcd,
                                            input logic [11:0] sp_bcd);
    logic [7:0] b;
    case (idx)
      4'd0:    b = ASC_H;
      4'd1:    b = ASC_R;
      4'd2:    b = ASC_COLON;
      4'd3:    b = digit_ascii(hr_bcd[11:8]);
      4'd4:    b = digit_ascii(hr_bcd[7:4]);
      4'd5:    b = digit_ascii(hr_bcd[3:0]);
      4'd6:    b = ASC_COMMA;
      4'd7:    b = ASC_S;
      4'd8:    b = ASC_P;
      4'd9:    b = ASC_COLON;
      4'd10:   b = digit_ascii(sp_bcd[11:8]);
      4'd11:   b = digit_ascii(sp_bcd[7:4]);
      4'd12:   b = digit_ascii(sp_bcd[3:0]);
      4'd13:   b = ASC_CR;
      4'd14:   b = ASC_LF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/telemetry_frame_fmt_if.sv
// Byte-stream valid/ready link from the formatter to the UART transmitter.
interface telemetry_frame_fmt_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/telemetry_frame_fmt_bin2bcd.sv
// Sequential 10-bit binary to 3-digit BCD converter (double dabble, 10 shift cycles).
module bin2bcd_seq
  import telemetry_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] bin,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       done
);

  logic [21:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        done_q, done_d;
  logic [21:0] adj_s;

  // Next-state: load on start, otherwise adjust digits and shift while running.
  always_comb begin
    adj_s  = {dd_adjust(shift_q[21:18]), dd_adjust(shift_q[17:14]),
              dd_adjust(shift_q[13:10]), shift_q[9:0]};
    shift_d = shift_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    if (start) begin
      shift_d = {12'd0, bin};
      cnt_d   = 4'd0;
      run_d   = 1'b1;
    end else if (run_q) begin
      shift_d = adj_s << 1;
      cnt_d   = cnt_q + 4'd1;
      if (cnt_q == 4'd9) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        run_d  = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 22'd0;
      cnt_q   <= 4'd0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign bcd2 = shift_q[21:18];
  assign bcd1 = shift_q[17:14];
  assign bcd0 = shift_q[13:10];
  assign done = done_q;

endmodule

// File: rtl/telemetry_frame_fmt.sv
// Periodic/on-demand telemetry formatter: streams "HR:ddd,SP:ddd\r\n" to the UART TX.
module telemetry_frame_fmt
  import telemetry_pkg::*;
#(
  parameter int PERIOD_CYC = 100_000,
  parameter int HR_MAX     = 999,
  parameter int SPO2_MAX   = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           data_heart_rate,
  input  logic [7:0]            data_spo2,
  input  logic                  send_now,
  telemetry_frame_fmt_if.master tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int               CNT_W    = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);
  localparam logic [15:0]      HR_CEIL  = 16'(HR_MAX);
  localparam logic [7:0]       SP_CEIL  = 8'(SPO2_MAX);
  localparam logic [3:0]       LAST_IDX = 4'(FRAME_LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             busy_q, tx_valid_q, frame_done_q, overrun_q;
  logic             frame_done_d, overrun_d;
  logic [7:0]       tx_data_q;

  logic             tick_s, req_s, conv_start_s, conv_done_s;
  logic             hr_done_s, sp_done_s;
  logic [9:0]       hr_sat_s, sp_sat_s;
  logic [11:0]      hr_bcd_s, sp_bcd_s;

  assign tick_s   = (cnt_q == CNT_LAST);
  assign req_s    = tick_s | send_now;
  assign hr_sat_s = (data_heart_rate > HR_CEIL) ? HR_CEIL[9:0] : data_heart_rate[9:0];
  assign sp_sat_s = {2'b00, (data_spo2 > SP_CEIL) ? SP_CEIL : data_spo2};

  // Free-running period counter, wraps to zero on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick_s) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The converters latch the saturated inputs on start, so they double as the frame snapshot.
  bin2bcd_seq u_hr_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start_s),
    .bin   (hr_sat_s),
    .bcd2  (hr_bcd_s[11:8]),
    .bcd1  (hr_bcd_s[7:4]),
    .bcd0  (hr_bcd_s[3:0]),
    .done  (hr_done_s)
  );

  bin2bcd_seq u_sp_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start_s),
    .bin   (sp_sat_s),
    .bcd2  (sp_bcd_s[11:8]),
    .bcd1  (sp_bcd_s[7:4]),
    .bcd0  (sp_bcd_s[3:0]),
    .done  (sp_done_s)
  );

  assign conv_done_s = hr_done_s & sp_done_s;

  // One-deep request queue: a second request while one is already pending is dropped.
  always_comb begin
    pending_d = pending_q;
    overrun_d = 1'b0;
    if (state_q == IDLE) begin
      pending_d = 1'b0;
    end else if (req_s) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end else begin
      pending_d = pending_q;
    end
  end

  // Frame sequencing: IDLE -> CONVERT (10 cycles) -> SEND (15 bytes) -> IDLE.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    conv_start_s = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s | pending_q) begin
          state_d      = CONVERT;
          conv_start_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CONVERT: begin
        if (conv_done_s) begin
          state_d = SEND;
          idx_d   = 4'd0;
        end else begin
          state_d = CONVERT;
        end
      end
      SEND: begin
        if (tx_valid_q & tx.tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d      = IDLE;
            idx_d        = 4'd0;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // State and registered outputs; tx_data only changes on acceptance or state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      busy_q       <= (state_d != IDLE);
      tx_valid_q   <= (state_d == SEND);
      tx_data_q    <= (state_d == SEND) ? frame_byte(idx_d, hr_bcd_s, sp_bcd_s) : 8'h00;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_telemetry_frame_fmt.sv
// Scoreboard bench for telemetry_frame_fmt: directed frames, saturation, backpressure, overrun, reset, periodic ticks.
module tb_telemetry_frame_fmt;

  logic        clk = 1'b0;
  logic        rst_n, rst_p_n, send_now, rand_en;
  logic [15:0] hr;
  logic [7:0]  sp;
  logic        busy, frame_done, overrun;
  logic        p_busy, p_frame_done, p_overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int bytes_acc = 0;
  int ovr_cnt = 0;
  int p_idx = 0;
  logic [7:0] exp_q[$];
  int p_stamps[$];

  telemetry_frame_fmt_if m_if ();
  telemetry_frame_fmt_if p_if ();

  telemetry_frame_fmt #(.PERIOD_CYC(100_000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_heart_rate (hr),
    .data_spo2       (sp),
    .send_now        (send_now),
    .tx              (m_if),
    .busy            (busy),
    .frame_done      (frame_done),
    .overrun         (overrun)
  );

  telemetry_frame_fmt #(.PERIOD_CYC(64)) dut_p (
    .clk             (clk),
    .rst_n           (rst_p_n),
    .data_heart_rate (16'd42),
    .data_spo2       (8'd97),
    .send_now        (1'b0),
    .tx              (p_if),
    .busy            (p_busy),
    .frame_done      (p_frame_done),
    .overrun         (p_overrun)
  );

  assign p_if.tx_ready = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    m_if.tx_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
    end
  endtask

  function automatic logic [7:0] model_byte(input int h_in, input int s_in, input int i);
    int h, s;
    logic [7:0] b;
    h = (h_in > 999) ? 999 : h_in;
    s = (s_in > 100) ? 100 : s_in;
    case (i)
      0: b = 8'h48;  1: b = 8'h52;  2: b = 8'h3A;
      3: b = 8'h30 + 8'(h / 100);
      4: b = 8'h30 + 8'((h / 10) % 10);
      5: b = 8'h30 + 8'(h % 10);
      6: b = 8'h2C;  7: b = 8'h53;  8: b = 8'h50;  9: b = 8'h3A;
      10: b = 8'h30 + 8'(s / 100);
      11: b = 8'h30 + 8'((s / 10) % 10);
      12: b = 8'h30 + 8'(s % 10);
      13: b = 8'h0D;
      14: b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  task automatic push_frame(input int h, input int s);
    for (int i = 0; i < 15; i++) exp_q.push_back(model_byte(h, s, i));
  endtask

  // Returns #1 after the edge that samples the request.
  task automatic send_req(input int h, input int s);
    @(posedge clk); #1;
    hr = 16'(h);
    sp = 8'(s);
    send_now = 1'b1;
    push_frame(h, s);
    @(posedge clk); #1;
    send_now = 1'b0;
  endtask

  task automatic pulse_send();
    @(posedge clk); #1;
    send_now = 1'b1;
    @(posedge clk); #1;
    send_now = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!frame_done && n < budget);
    check(name, frame_done, 1);
  endtask

  task automatic mon_main();
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", m_if.tx_valid, 1);
          check("hold_data", m_if.tx_data, prev_data);
        end
        if (m_if.tx_valid && m_if.tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL byte_unexpected: got 0x%02h, expected no byte", m_if.tx_data);
          end else begin
            e = exp_q.pop_front();
            check("byte", m_if.tx_data, e);
          end
          bytes_acc++;
        end
        if (overrun) ovr_cnt++;
        prev_stall = m_if.tx_valid & ~m_if.tx_ready;
        prev_data  = m_if.tx_data;
      end
    end
  endtask

  task automatic mon_p();
    forever begin
      @(negedge clk);
      if (rst_p_n) begin
        if (p_if.tx_valid && p_if.tx_ready) begin
          check("p_byte", p_if.tx_data, model_byte(42, 97, p_idx));
          p_idx = (p_idx + 1) % 15;
        end
        if (p_frame_done) begin
          p_stamps.push_back(cyc);
          check("p_idle_at_done", p_busy, 0);
          check("p_no_overrun", p_overrun, 0);
        end
      end
    end
  endtask

  initial begin
    int n;
    int ovr0;
    rst_n = 1'b0;
    rst_p_n = 1'b0;
    send_now = 1'b0;
    rand_en = 1'b0;
    hr = 16'd0;
    sp = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_data", m_if.tx_data, 0);
    check("rst_tx_valid", m_if.tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    rst_p_n = 1'b1;
    fork
      mon_main();
      mon_p();
    join_none

    // Basic frame with latency measurement
    send_req(75, 98);
    check("busy_after_req", busy, 1);
    n = 0;
    while (!m_if.tx_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("valid_latency", n, 11);
    n = 0;
    while (!frame_done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_latency", n, 15);

    // Saturation and all-zero frames
    send_req(1234, 200);
    wait_done("done_sat", 60);
    send_req(0, 0);
    wait_done("done_zero", 60);

    // Random backpressure
    rand_en = 1'b1;
    send_req(125, 80);
    wait_done("done_rand", 400);
    rand_en = 1'b0;

    // Inputs change mid-frame
    send_req(75, 98);
    n = 0;
    while (!m_if.tx_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    hr = 16'd125;
    wait_done("done_mid_a", 60);
    send_req(125, 98);
    wait_done("done_mid_b", 60);

    // Three extra requests during a frame: one follow-on, two drops
    ovr0 = ovr_cnt;
    send_req(10, 20);
    repeat (4) @(posedge clk);
    pulse_send();
    push_frame(10, 20);
    pulse_send();
    pulse_send();
    wait_done("done_ovr_a", 60);
    wait_done("done_ovr_b", 60);
    check("overrun_pulses", ovr_cnt - ovr0, 2);
    repeat (40) @(posedge clk);
    #1;
    check("idle_after_ovr", busy, 0);

    // Reset in the middle of a frame
    bytes_acc = 0;
    send_req(75, 98);
    n = 0;
    while (bytes_acc < 6 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_byte6", bytes_acc, 6);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", m_if.tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", m_if.tx_data, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_req(33, 44);
    wait_done("done_after_rst", 60);

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", exp_q.size(), 0);
    check("p_enough_frames", int'(p_stamps.size() >= 4), 1);
    for (int i = 1; i < 4 && i < p_stamps.size(); i++) begin
      check("p_period", p_stamps[i] - p_stamps[i-1], 64);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
